// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked byte
// transfer driven by the device, ACK check and timeout supervision.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [InhW-1:0] InhLast = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t state, stateNext;

    logic [1:0]      clkSync, dataSync;
    logic            clkPrev;
    logic            clkS, dataS, fall;
    logic [8:0]      shift, shiftNext;
    logic [3:0]      bitCnt, bitCntNext, bitCntInc;
    logic [InhW-1:0] inhCnt, inhCntNext;
    logic [ToW-1:0]  toCnt, toCntNext;
    logic            clkOeNext, dataOeNext;
    logic            doneNext, errNext;
    logic            supervised, timedOut;

    // Synchronizers idle high so reset never produces a spurious fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
            clkPrev  <= 1'b1;
        end else begin
            clkSync  <= {clkSync[0], ps2_clk_in};
            dataSync <= {dataSync[0], ps2_data_in};
            clkPrev  <= clkSync[1];
        end
    end

    assign clkS  = clkSync[1];
    assign dataS = dataSync[1];
    assign fall  = clkPrev & ~clkS;

    assign bitCntInc  = bitCnt + 4'd1;
    assign supervised = (state == REQ) || (state == SEND) ||
                        (state == ACK) || (state == WAIT_IDLE);
    assign timedOut   = supervised && (toCnt == ToLast);

    always_comb begin
        stateNext  = state;
        shiftNext  = shift;
        bitCntNext = bitCnt;
        inhCntNext = inhCnt;
        toCntNext  = toCnt;
        clkOeNext  = ps2_clk_oe;
        dataOeNext = ps2_data_oe;
        doneNext   = 1'b0;
        errNext    = 1'b0;

        unique case (state)
            IDLE: begin
                clkOeNext  = 1'b0;
                dataOeNext = 1'b0;
                if (tx_valid) begin
                    shiftNext  = {~^tx_data, tx_data};
                    bitCntNext = '0;
                    inhCntNext = '0;
                    toCntNext  = '0;
                    clkOeNext  = 1'b1;
                    stateNext  = INHIBIT;
                end
            end
            INHIBIT: begin
                clkOeNext  = 1'b1;
                dataOeNext = 1'b0;
                if (inhCnt == InhLast) begin
                    clkOeNext  = 1'b0;
                    dataOeNext = 1'b1;
                    toCntNext  = '0;
                    bitCntNext = '0;
                    stateNext  = REQ;
                end else begin
                    inhCntNext = inhCnt + 1'b1;
                end
            end
            REQ: begin
                clkOeNext  = 1'b0;
                dataOeNext = 1'b1;
                bitCntNext = '0;
                if (fall) begin
                    stateNext = SEND;
                end
            end
            SEND: begin
                clkOeNext  = 1'b0;
                dataOeNext = ~shift[bitCnt];
                if (fall) begin
                    if (bitCnt == 4'd8) begin
                        dataOeNext = 1'b0;
                        stateNext  = ACK;
                    end else begin
                        bitCntNext = bitCntInc;
                        dataOeNext = ~shift[bitCntInc];
                    end
                end
            end
            ACK: begin
                clkOeNext  = 1'b0;
                dataOeNext = 1'b0;
                if (fall) begin
                    if (dataS) begin
                        errNext   = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        stateNext = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                clkOeNext  = 1'b0;
                dataOeNext = 1'b0;
                if (clkS && dataS) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                clkOeNext  = 1'b0;
                dataOeNext = 1'b0;
                stateNext  = IDLE;
            end
        endcase

        // Timeout overrides any coincident fall or idle detection.
        if (supervised) begin
            if (timedOut) begin
                stateNext  = IDLE;
                clkOeNext  = 1'b0;
                dataOeNext = 1'b0;
                doneNext   = 1'b0;
                errNext    = 1'b1;
            end else begin
                toCntNext = toCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            bitCnt      <= '0;
            inhCnt      <= '0;
            toCnt       <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= stateNext;
            shift       <= shiftNext;
            bitCnt      <= bitCntNext;
            inhCnt      <= inhCntNext;
            toCnt       <= toCntNext;
            ps2_clk_oe  <= clkOeNext;
            ps2_data_oe <= dataOeNext;
            done        <= doneNext;
            err         <= errNext;
        end
    end

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector bus and a
// behavioural PS/2 device that clocks the host's byte in.
module tb_ps2_host_tx;

    localparam int HALF = 25;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       devClkLow, devDataLow;
    logic       clkPin, dataPin;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int doneCnt = 0;
    int errCnt = 0;
    int clkOeCycles = 0;
    int pulseBad = 0;

    assign clkPin  = ~(ps2_clk_oe | devClkLow);
    assign dataPin = ~(ps2_data_oe | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done),
        .err(err),
        .ps2_clk_in(clkPin),
        .ps2_data_in(dataPin),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            doneCnt     <= doneCnt + int'(done);
            errCnt      <= errCnt + int'(err);
            clkOeCycles <= clkOeCycles + int'(ps2_clk_oe);
            if ((done || err) && (busy || !tx_ready)) pulseBad <= pulseBad + 1;
            if (done && err) pulseBad <= pulseBad + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic devWait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitRequest(output bit ok);
        int i;
        ok = 1'b0;
        for (i = 0; i < 200 && !ps2_clk_oe; i++) @(negedge clk);
        if (!ps2_clk_oe) return;
        for (i = 0; i < 200 && ps2_clk_oe; i++) @(negedge clk);
        ok = !ps2_clk_oe;
    endtask

    task automatic clockBits(input int n, output logic [9:0] got);
        got = '0;
        for (int k = 0; k < n; k++) begin
            devWait(HALF);
            devClkLow = 1'b1;
            devWait(HALF);
            got[k] = dataPin;
            devClkLow = 1'b0;
        end
    endtask

    task automatic ackPulse(input bit ack);
        devWait(HALF / 2);
        devDataLow = ack;
        devWait(HALF - HALF / 2);
        devClkLow = 1'b1;
        devWait(HALF);
        devClkLow = 1'b0;
        devWait(HALF / 2);
        devDataLow = 1'b0;
    endtask

    task automatic devReceive(input bit ack, output logic [10:0] rx,
                              output bit ok);
        logic       start;
        logic [9:0] got;
        waitRequest(ok);
        devWait(HALF);
        start = dataPin;
        clockBits(10, got);
        check("stop_released_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        ackPulse(ack);
        rx = {got, start};
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done || err) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic sendPulse(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [10:0] rx;
        bit          ok;
        int          d0, e0, c0, t0, t1;

        rst        = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        devWait(5);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", {30'd0, done, err}, 32'd0);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        devWait(2);

        // 0xED with ACK
        d0 = doneCnt; e0 = errCnt; c0 = clkOeCycles;
        sendPulse(8'hED);
        check("ed_busy", 32'(busy), 32'd1);
        devReceive(1'b1, rx, ok);
        check("ed_request_seen", 32'(ok), 32'd1);
        waitDone(ok);
        check("ed_done_seen", 32'(ok), 32'd1);
        check("ed_done_pulse", {30'd0, done, err}, 32'd2);
        check("ed_ready_at_done", {30'd0, tx_ready, busy}, 32'd2);
        devWait(3);
        check("ed_bits", 32'(rx), 32'h7DA);
        check("ed_inhibit_len", 32'(clkOeCycles - c0), 32'd20);
        check("ed_done_cnt", 32'(doneCnt - d0), 32'd1);
        check("ed_err_cnt", 32'(errCnt - e0), 32'd0);

        // 0x07 then 0x00 with tx_valid held
        d0 = doneCnt; e0 = errCnt;
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h00;
        devReceive(1'b1, rx, ok);
        waitDone(ok);
        check("b2b_first_done", {30'd0, done, tx_ready}, 32'd3);
        @(negedge clk);
        check("b2b_inhibit_next", {30'd0, ps2_clk_oe, busy}, 32'd3);
        tx_valid = 1'b0;
        check("b2b_bits_07", 32'(rx), 32'h40E);
        devReceive(1'b1, rx, ok);
        waitDone(ok);
        check("b2b_second_done", 32'(done), 32'd1);
        devWait(3);
        check("b2b_bits_00", 32'(rx), 32'h600);
        check("b2b_done_cnt", 32'(doneCnt - d0), 32'd2);
        check("b2b_err_cnt", 32'(errCnt - e0), 32'd0);

        // NACK
        d0 = doneCnt; e0 = errCnt;
        sendPulse(8'hF4);
        devReceive(1'b0, rx, ok);
        waitIdle(ok);
        devWait(3);
        check("nack_idle", 32'(tx_ready), 32'd1);
        check("nack_err_cnt", 32'(errCnt - e0), 32'd1);
        check("nack_done_cnt", 32'(doneCnt - d0), 32'd0);
        check("nack_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("nack_bits", 32'(rx), 32'h5E8);

        // Timeout: device never clocks
        d0 = doneCnt; e0 = errCnt;
        t0 = 0; t1 = 0;
        sendPulse(8'h12);
        for (int i = 0; i < 100 && !ps2_data_oe; i++) @(negedge clk);
        check("to_req_entry", 32'(ps2_data_oe), 32'd1);
        t0 = cyc;
        for (int i = 0; i < 6000 && !err; i++) @(negedge clk);
        t1 = cyc;
        check("to_err_seen", 32'(err), 32'd1);
        check("to_latency", 32'(t1 - t0), 32'd5000);
        check("to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("to_ready", 32'(tx_ready), 32'd1);
        devWait(3);
        check("to_done_cnt", 32'(doneCnt - d0), 32'd0);

        // 0x55 request during an 0xFF transfer is ignored
        d0 = doneCnt;
        sendPulse(8'hFF);
        devWait(5);
        sendPulse(8'h55);
        devReceive(1'b1, rx, ok);
        waitDone(ok);
        check("ign_done", 32'(done), 32'd1);
        devWait(2);
        check("ign_bits", 32'(rx), 32'h7FE);
        c0 = clkOeCycles;
        devWait(60);
        check("ign_no_requeue", 32'(clkOeCycles - c0), 32'd0);
        check("ign_done_cnt", 32'(doneCnt - d0), 32'd1);

        // Reset during SEND after four bits of 0xA5
        d0 = doneCnt; e0 = errCnt;
        sendPulse(8'hA5);
        waitRequest(ok);
        devWait(HALF);
        begin
            logic [9:0] g;
            clockBits(4, g);
            check("rst_mid_bits", 32'(g[3:0]), 32'h5);
        end
        devWait(5);
        check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("mid_rst_ready", 32'(tx_ready), 32'd1);
        check("mid_rst_pulses", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        devWait(50);
        check("mid_rst_cnts", 32'((doneCnt - d0) + (errCnt - e0)), 32'd0);
        check("pulse_rules", 32'(pulseBad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable). It is the write-direction counterpart of the keyboard receive path and shares the same open-collector PS2_CLK/PS2_DATA pins. While it owns the bus, `busy` is high and the receive path ignores bus activity.

Parameters:
INHIBIT_CYCLES, 10000, number of clk cycles the host holds PS2_CLK low before the request (100 us at 100 MHz).
TIMEOUT_CYCLES, 2000000, maximum clk cycles from request start to transfer completion (20 ms at 100 MHz).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
tx_data  in  8  command byte; sampled at handshake
tx_valid  in  1  request to send tx_data
tx_ready  out  1  high only in IDLE; transfer accepted when tx_valid && tx_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: byte sent and device ACKed
err  out  1  one-cycle pulse: NACK or timeout
ps2_clk_in  in  1  raw PS2_CLK pin value
ps2_data_in  in  1  raw PS2_DATA pin value
ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release (top level ties pin to 1'b0 or 'z)
ps2_data_oe  out  1  1 = drive PS2_DATA low, 0 = release

Behaviour:
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
  - fall = (synced clk was 1 last cycle) && (synced clk is 0 now).
  - Total latency from pin edge to `fall` is 3 clk cycles.
- Reset:
  - State goes to IDLE.
  - tx_ready=1; busy=0, done=0, err=0, ps2_clk_oe=0, ps2_data_oe=0.
  - Counters and the shift register are cleared.
  - If rst is asserted mid-transfer, both oe outputs release on the next cycle and neither done nor err pulses.
- Registered outputs: all outputs are registered except tx_ready and busy, which decode directly from the state.
- FSM states and transitions:
  - IDLE:
    - Both oe = 0.
    - On tx_valid: latch tx_data into shift[7:0], set shift[8] = ~^tx_data (odd parity), clear counters, go to INHIBIT.
    - tx_valid is ignored in every other state; no queuing.
  - INHIBIT:
    - ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles.
    - `fall` is ignored here.
    - Then go to REQ.
    - The timeout counter starts on entry to REQ.
  - REQ:
    - ps2_clk_oe=0, ps2_data_oe=1 (start bit 0); bit counter = 0.
    - On the first `fall`, go to SEND.
  - SEND:
    - Bit i (i = 0..7 data LSB first, 8 = parity) is presented by setting ps2_data_oe = ~shift[i].
    - The first bit is presented in the cycle after entering SEND from REQ. Each following bit is presented in the cycle after the next `fall`.
    - On the `fall` following the parity bit: ps2_data_oe=0 (stop bit released), go to ACK.
  - ACK:
    - On the next `fall`, sample synced data.
    - 0: go to WAIT_IDLE.
    - 1 (NACK): pulse err, go to IDLE.
  - WAIT_IDLE:
    - When synced clk==1 and synced data==1: pulse done, go to IDLE.
- Timeout:
  - The timeout counter runs in REQ, SEND, ACK and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: pulse err, release both oe, go to IDLE.
  - Timeout has priority over a coincident `fall` or a coincident idle detection.
- Pulse timing:
  - done and err are high exactly one cycle: the cycle in which the state is first IDLE again.
  - tx_ready is high in that same cycle.
  - A new tx_valid is accepted that cycle.
  - done and err are never both high.
- Safe-drive rule: ps2_clk_oe and ps2_data_oe are never asserted outside INHIBIT, REQ and SEND.

Test Plan:
- Send 0xED with INHIBIT_CYCLES=20 and the device model clocking at 10 kHz (accelerated OK):
  - clk_oe high for exactly 20 cycles.
  - The model samples on rising edges and reads 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - The model drives ACK 0 → single-cycle done, no err, busy falls the same cycle.
- Send 0x07 then 0x00 back-to-back, with tx_valid held high:
  - Parity 0 for 0x07, parity 1 for 0x00.
  - The second byte's INHIBIT starts the cycle after the first done.
- NACK: the model leaves data high at the 11th clock → err pulse, no done, both oe=0, back in IDLE.
- Timeout: TIMEOUT_CYCLES=5000 and the model never clocks after the request → err pulse exactly 5000 cycles after REQ entry; oe released.
- Assert rst during SEND after 4 bits → next cycle both oe=0, tx_ready=1, no done/err.
- Pulse tx_valid with 0x55 during an in-progress 0xFF transfer → ignored; only 0xFF appears on the bus.
